// File: rtl/mem_ctrl_if.sv
// Request/response and RAM pin bundle shared by mem_ctrl, icache, LSB and RAM.
// master = requesters plus RAM side, slave = the controller.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        output if_req, if_addr,
        output ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        output mem_din,
        input  if_done, if_data, ls_done, ls_rdata,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        input  mem_din,
        output if_done, if_data, ls_done, ls_rdata,
        output mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter for the single RAM/IO port: LS has priority over IF,
// reads assemble little-endian, stores to IO stall on io_buffer_full.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      flush,
    input  logic      io_buffer_full,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, WAIT_IO} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic        skip_q, skip_d;
    logic        rdy_q;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        issue;
    logic [31:0] iss_base;
    logic [1:0]  iss_idx;
    logic [31:0] iss_data;
    logic [31:0] iss_a;
    logic [2:0]  ls_len;
    logic [2:0]  cnt_dec;
    logic [2:0]  cnt_inc;
    logic [1:0]  cap_idx;

    assign cnt_dec = cnt_q - 3'd1;
    assign cnt_inc = cnt_q + 3'd1;
    assign cap_idx = cnt_dec[1:0];

    always_comb begin
        unique case (bus.ls_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        skip_d     = skip_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        issue      = 1'b0;
        iss_base   = addr_q;
        iss_idx    = cnt_q[1:0];
        iss_data   = wdata_q;
        iss_a      = 32'd0;

        if (rdy_in) begin
            mem_wr_d  = 1'b0;
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!if_done_q && !ls_done_q && !flush) begin
                        if (bus.ls_req) begin
                            owner_d = 1'b1;
                            addr_d  = bus.ls_addr;
                            len_d   = ls_len;
                            wdata_d = bus.ls_wdata;
                            cnt_d   = 3'd0;
                            buf_d   = 32'd0;
                            skip_d  = 1'b0;
                            if (bus.ls_wr) begin
                                issue    = 1'b1;
                                iss_base = bus.ls_addr;
                                iss_idx  = 2'd0;
                                iss_data = bus.ls_wdata;
                            end else begin
                                state_d = READ;
                                mem_a_d = bus.ls_addr;
                            end
                        end else if (bus.if_req) begin
                            owner_d = 1'b0;
                            addr_d  = bus.if_addr;
                            len_d   = 3'd4;
                            cnt_d   = 3'd0;
                            buf_d   = 32'd0;
                            skip_d  = 1'b0;
                            state_d = READ;
                            mem_a_d = bus.if_addr;
                        end
                    end
                end
                READ: begin
                    if (flush) begin
                        state_d = IDLE;
                        mem_a_d = 32'd0;
                        cnt_d   = 3'd0;
                    end else if (!rdy_q && cnt_q != 3'd0) begin
                        // byte for cnt-1 was lost while frozen: re-drive its address
                        cnt_d   = cnt_dec;
                        mem_a_d = addr_q + {29'd0, cnt_dec};
                        skip_d  = 1'b1;
                    end else begin
                        skip_d = 1'b0;
                        if (cnt_q != 3'd0 && !skip_q)
                            buf_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
                        if (cnt_q == len_q) begin
                            state_d = IDLE;
                            mem_a_d = 32'd0;
                            cnt_d   = 3'd0;
                            if (owner_q) begin
                                ls_rdata_d = buf_d;
                                ls_done_d  = 1'b1;
                            end else begin
                                if_data_d = buf_d;
                                if_done_d = 1'b1;
                            end
                        end else begin
                            cnt_d   = cnt_inc;
                            mem_a_d = (cnt_inc == len_q) ? 32'd0
                                    : addr_q + {29'd0, cnt_inc};
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d   = IDLE;
                        cnt_d     = 3'd0;
                        ls_done_d = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        iss_idx = cnt_inc[1:0];
                    end
                end
                WAIT_IO: begin
                    issue = 1'b1;
                end
            endcase

            if (issue) begin
                iss_a   = iss_base + {30'd0, iss_idx};
                mem_a_d = iss_a;
                cnt_d   = {1'b0, iss_idx};
                if (iss_a >= IO_BASE && io_buffer_full) begin
                    state_d = WAIT_IO;
                end else begin
                    state_d    = WRITE;
                    mem_wr_d   = 1'b1;
                    mem_dout_d = iss_data[{iss_idx, 3'b000} +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            addr_q     <= 32'd0;
            len_q      <= 3'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= 3'd0;
            buf_q      <= 32'd0;
            skip_q     <= 1'b0;
            rdy_q      <= 1'b1;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            skip_q     <= skip_d;
            rdy_q      <= rdy_in;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // a frozen cycle must neither write nor be taken as a completion
    assign bus.mem_wr   = mem_wr_q & rdy_in;
    assign bus.if_done  = if_done_q & rdy_in;
    assign bus.ls_done  = ls_done_q & rdy_in;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: stimulus pushes expectations into queues,
// a negedge monitor pops them on every done pulse and every written byte.
module tb_mem_ctrl;
    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic rdy    = 1'b1;
    logic flush  = 1'b0;
    logic iofull = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .flush          (flush),
        .io_buffer_full (iofull),
        .bus            (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
        bit          dchk;
    } exp_t;

    exp_t q_if[$];
    exp_t q_ls[$];
    exp_t q_wr[$];

    int cmp_n   = 0;
    int err_n   = 0;
    int cyc     = 0;
    int if_seen = 0;

    logic [7:0] ram [bit [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: read data appears the cycle after its address
    always @(posedge clk) begin
        bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.if_done) begin
            if_seen++;
            chk("if_done expected", 32'(q_if.size() != 0), 32'd1);
            if (q_if.size() != 0) begin
                e = q_if.pop_front();
                chk("if_data", bus.if_data, e.d);
                if (e.cyc >= 0) chk("if_done cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (bus.ls_done) begin
            chk("ls_done expected", 32'(q_ls.size() != 0), 32'd1);
            if (q_ls.size() != 0) begin
                e = q_ls.pop_front();
                if (e.dchk) chk("ls_rdata", bus.ls_rdata, e.d);
                if (e.cyc >= 0) chk("ls_done cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (bus.mem_wr) begin
            chk("write expected", 32'(q_wr.size() != 0), 32'd1);
            if (q_wr.size() != 0) begin
                e = q_wr.pop_front();
                chk("write addr", bus.mem_a, e.a);
                chk("write data", {24'd0, bus.mem_dout}, e.d);
                if (e.cyc >= 0) chk("write cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic ls_op(input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp, input int lat, input int wo);
        int c0 = cyc;
        int n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bit seen = 1'b0;
        q_ls.push_back('{a, exp, (lat < 0) ? -1 : c0 + lat, !wr});
        if (wr) begin
            for (int k = 0; k < n; k++)
                q_wr.push_back('{a + 32'(k), {24'd0, wd[8*k +: 8]},
                                 (wo < 0) ? -1 : c0 + wo + k, 1'b1});
        end
        bus.ls_req   = 1'b1;
        bus.ls_wr    = wr;
        bus.ls_size  = sz;
        bus.ls_addr  = a;
        bus.ls_wdata = wd;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.ls_done;
        end
        cmp_n++;
        if (!seen) begin
            err_n++;
            $display("FAIL ls_done timeout @%h: got none want pulse", a);
        end
        @(posedge clk);
        #1;
        bus.ls_req = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] a, input logic [31:0] exp,
                         input int lat);
        int c0 = cyc;
        bit seen = 1'b0;
        q_if.push_back('{a, exp, (lat < 0) ? -1 : c0 + lat, 1'b1});
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.if_done;
        end
        cmp_n++;
        if (!seen) begin
            err_n++;
            $display("FAIL if_done timeout @%h: got none want pulse", a);
        end
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int seen0;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'd0;
        bus.ls_req   = 1'b0;
        bus.ls_wr    = 1'b0;
        bus.ls_size  = 2'd0;
        bus.ls_addr  = 32'd0;
        bus.ls_wdata = 32'd0;
        ram[32'h100]  = 8'h13;
        ram[32'h101]  = 8'h05;
        ram[32'h102]  = 8'h00;
        ram[32'h103]  = 8'h00;
        ram[32'h2000] = 8'h9C;
        ram[32'h200]  = 8'h78;
        ram[32'h201]  = 8'h56;
        ram[32'h202]  = 8'h34;
        ram[32'h203]  = 8'h12;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst mem_a", bus.mem_a, 32'd0);
        chk("rst mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst if_done", 32'(bus.if_done), 32'd0);
        chk("rst ls_done", 32'(bus.ls_done), 32'd0);
        chk("rst if_data", bus.if_data, 32'd0);
        chk("rst ls_rdata", bus.ls_rdata, 32'd0);
        @(posedge clk);
        #1;

        // word fetch and its address sequence
        fork
            if_op(32'h100, 32'h0000_0513, 6);
            begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("fetch mem_a", bus.mem_a, 32'h100 + 32'(k));
                end
            end
        join

        // LS wins the tie, IF starts after the LS done cycle
        fork
            ls_op(1'b0, 2'd0, 32'h2000, 32'd0, 32'h0000_009C, 3, -1);
            if_op(32'h100, 32'h0000_0513, 10);
        join

        ls_op(1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF, 32'd0, 5, 1);
        ls_op(1'b0, 2'd2, 32'h40, 32'd0, 32'hDEAD_BEEF, 6, -1);
        ls_op(1'b0, 2'd1, 32'h41, 32'd0, 32'h0000_ADBE, 4, -1);

        // IO store held off by a full buffer for 3 cycles
        fork
            ls_op(1'b1, 2'd0, 32'h0003_0000, 32'h77, 32'd0, 5, 4);
            begin
                iofull = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                iofull = 1'b0;
            end
        join

        // half store straddling IO_BASE: only the IO byte waits
        fork
            ls_op(1'b1, 2'd1, 32'h0002_FFFF, 32'h0000_BBAA, 32'd0, 4, -1);
            begin
                iofull = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("straddle wr c1", 32'(bus.mem_wr), 32'd1);
                @(posedge clk);
                #1;
                iofull = 1'b0;
                @(negedge clk);
                chk("straddle wr c2", 32'(bus.mem_wr), 32'd0);
                @(negedge clk);
                chk("straddle wr c3", 32'(bus.mem_wr), 32'd1);
            end
        join

        // flush in the 2nd READ cycle of a fetch
        c0    = cyc;
        seen0 = if_seen;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush      = 1'b1;
        bus.if_req = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush idle mem_a", bus.mem_a, 32'd0);
        repeat (8) @(posedge clk);
        chk("flush no if_done", 32'(if_seen - seen0), 32'd0);
        #1;

        // flush during a store is ignored
        fork
            ls_op(1'b1, 2'd2, 32'h80, 32'h1122_3344, 32'd0, 5, 1);
            begin
                repeat (2) @(posedge clk);
                #1;
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
        join

        // freeze mid word load
        fork
            ls_op(1'b0, 2'd2, 32'h200, 32'd0, 32'h1234_5678, -1, -1);
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rdy = 1'b1;
            end
        join

        // freeze mid word store
        fork
            ls_op(1'b1, 2'd2, 32'h300, 32'hCAFE_F00D, 32'd0, -1, -1);
            begin
                repeat (2) @(posedge clk);
                #1;
                rdy = 1'b0;
                @(negedge clk);
                chk("frozen mem_wr", 32'(bus.mem_wr), 32'd0);
                @(posedge clk);
                #1;
                rdy = 1'b1;
            end
        join
        ls_op(1'b0, 2'd3, 32'h300, 32'd0, 32'hCAFE_F00D, 6, -1);

        // reset in the middle of a store
        c0 = cyc;
        q_wr.push_back('{32'h60, 32'h5A, c0 + 1, 1'b1});
        bus.ls_req   = 1'b1;
        bus.ls_wr    = 1'b1;
        bus.ls_size  = 2'd2;
        bus.ls_addr  = 32'h60;
        bus.ls_wdata = 32'hA5A5_5A5A;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.ls_req = 1'b0;
        @(negedge clk);
        chk("mid-rst mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("mid-rst mem_a", bus.mem_a, 32'd0);
        chk("mid-rst mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("mid-rst ls_done", 32'(bus.ls_done), 32'd0);
        chk("mid-rst if_data", bus.if_data, 32'd0);
        chk("mid-rst ls_rdata", bus.ls_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        ls_op(1'b0, 2'd1, 32'h60, 32'd0, 32'h0000_005A, 4, -1);

        repeat (5) @(posedge clk);
        chk("leftover if", 32'(q_if.size()), 32'd0);
        chk("leftover ls", 32'(q_ls.size()), 32'd0);
        chk("leftover wr", 32'(q_wr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
